// File: rtl/ddr3_app_responder.sv
// ddr3_app_responder
//
// Stand-in for a DDR3 memory controller on its user ("app") interface. It lets a
// traffic generator run without a PHY. The model covers calibration delay,
// command backpressure, refresh stalls and fixed-latency in-order read return,
// backed by a small aliased memory.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   app_en/app_cmd/      command valid, opcode (000 write, 001 read), address
//   app_addr               address layout {1'b0, bank[2:0], row[13:0], col[9:0]}
//   app_wdf_*            write data, data valid, last beat, byte mask (1 = keep)
//   app_burst            ignored
//   sr_req, ref_req      self-refresh / refresh requests (handled identically)
//   app_rdy              command accept
//   wr_data_rdy          write data accept
//   app_rd_data(_valid)  read return, RD_LATENCY cycles after the accept cycle
//   init_calib_complete  sticky calibration-done flag
//   proto_err            sticky protocol violation flag
//   wr_count, rd_count   accepted write / read counters (wrap at 2^32)
//
// Build option
//   DDR_RESP_RAND_STALL_EN  when defined, app_rdy stalls come from a 16-bit LFSR
//                           instead of the fixed STALL_PERIOD pattern, and
//                           wr_data_rdy is also dropped pseudo-randomly.
module ddr3_app_responder #(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 256,
  parameter int APP_MASK_WIDTH = 32,
  parameter int IDX_W          = 7,
  parameter int CALIB_CYCLES   = 64,
  parameter int RD_LATENCY     = 4,
  parameter int STALL_PERIOD   = 16,
  parameter int REF_CYCLES     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      app_en,
  input  logic [2:0]                app_cmd,
  input  logic [ADDR_WIDTH-1:0]     app_addr,
  input  logic [APP_DATA_WIDTH-1:0] app_wdf_data,
  input  logic                      app_wdf_wren,
  input  logic                      app_wdf_end,
  input  logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
  input  logic                      app_burst,
  input  logic                      sr_req,
  input  logic                      ref_req,
  output logic                      app_rdy,
  output logic                      wr_data_rdy,
  output logic [APP_DATA_WIDTH-1:0] app_rd_data,
  output logic                      app_rd_data_valid,
  output logic                      init_calib_complete,
  output logic                      proto_err,
  output logic [31:0]               wr_count,
  output logic [31:0]               rd_count
);

  localparam logic [1:0] CALIB   = 2'd0;
  localparam logic [1:0] READY   = 2'd1;
  localparam logic [1:0] REFRESH = 2'd2;
  localparam int         DEPTH   = 1 << IDX_W;

  logic [1:0]  state;
  logic [31:0] cal_cnt;
  logic [31:0] ref_cnt;
  logic        stall;
  logic        refresh_req;

  assign refresh_req = ref_req | sr_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= CALIB;
      cal_cnt             <= '0;
      ref_cnt             <= '0;
      init_calib_complete <= 1'b0;
    end else begin
      case (state)
        CALIB: begin
          if (cal_cnt == 32'(CALIB_CYCLES - 1)) begin
            state               <= READY;
            init_calib_complete <= 1'b1;
          end else begin
            cal_cnt <= cal_cnt + 32'd1;
          end
        end
        READY: begin
          if (refresh_req) begin
            state   <= REFRESH;
            ref_cnt <= '0;
          end
        end
        REFRESH: begin
          // A new request while refreshing restarts the refresh window.
          if (refresh_req) begin
            ref_cnt <= '0;
          end else if (ref_cnt == 32'(REF_CYCLES - 1)) begin
            state <= READY;
          end else begin
            ref_cnt <= ref_cnt + 32'd1;
          end
        end
        default: state <= CALIB;
      endcase
    end
  end

`ifdef DDR_RESP_RAND_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall       = (lfsr[3:0] == 4'hF);
  assign wr_data_rdy = (state == READY) & (lfsr[7:4] != 4'h0);
`else
  logic [31:0] per_cnt;

  // Free-running period counter; one stall cycle at the end of each period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
    end else if ((STALL_PERIOD == 0) || (per_cnt == 32'(STALL_PERIOD - 1))) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 32'd1;
    end
  end

  assign stall       = (STALL_PERIOD != 0) && (per_cnt == 32'(STALL_PERIOD - 1));
  assign wr_data_rdy = (state == READY);
`endif

  assign app_rdy = (state == READY) & ~stall;

  logic accept, wr_acc, rd_acc, bad_cmd, wr_commit, proto_hit;

  assign accept    = app_en & app_rdy;
  assign wr_acc    = accept & (app_cmd == 3'b000);
  assign rd_acc    = accept & (app_cmd == 3'b001);
  assign bad_cmd   = accept & (app_cmd != 3'b000) & (app_cmd != 3'b001);
  assign wr_commit = wr_acc & app_wdf_wren & wr_data_rdy;
  assign proto_hit = bad_cmd
                   | (wr_acc & ~(app_wdf_wren & wr_data_rdy))
                   | (app_wdf_wren & ~wr_acc)
                   | (app_wdf_end ^ app_wdf_wren)
                   | (app_en & (state == CALIB));

  // Aliased index: col[9:3] ^ row[6:0] ^ bank, resized to the memory depth.
  logic [6:0]       idx7;
  logic [IDX_W-1:0] idx;

  assign idx7 = app_addr[9:3] ^ app_addr[16:10] ^ {4'b0000, app_addr[26:24]};
  assign idx  = IDX_W'(idx7);

  logic unused_ok;
  assign unused_ok = &{1'b0, app_burst, app_addr[ADDR_WIDTH-1:27],
                       app_addr[23:17], app_addr[2:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count  <= '0;
      rd_count  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (wr_acc) wr_count <= wr_count + 32'd1;
      if (rd_acc) rd_count <= rd_count + 32'd1;
      if (proto_hit) proto_err <= 1'b1;
    end
  end

  logic [APP_DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int b = 0; b < APP_MASK_WIDTH; b++) begin
        if (!app_wdf_mask[b]) mem[idx][b*8 +: 8] <= app_wdf_data[b*8 +: 8];
      end
    end
  end

  logic [APP_DATA_WIDTH-1:0] data_p [RD_LATENCY];
  logic [RD_LATENCY-1:0]     vld_p;

  // Read return pipeline: stage 0 samples memory at the accept edge, the last
  // stage is the output. Data stages load only with valid, so the output
  // holds its last value between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
      for (int i = 0; i < RD_LATENCY; i++) data_p[i] <= '0;
    end else begin
      vld_p[0] <= rd_acc;
      if (rd_acc) data_p[0] <= mem[idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) data_p[i] <= data_p[i-1];
      end
    end
  end

  assign app_rd_data       = data_p[RD_LATENCY-1];
  assign app_rd_data_valid = vld_p[RD_LATENCY-1];

endmodule

// File: doc/ddr3_app_responder.md
Name: ddr3_app_responder

Overview:
Synthesizable/simulation responder for the DDR3 controller user ("app") interface. It stands in for the memory controller so the traffic generator (initiator) can be exercised without a PHY. The block models calibration delay, command backpressure, refresh stalls and fixed-latency in-order read return, backed by a small aliased memory array. It sits where the controller IP normally sits, with the generator's outputs as its inputs.

Parameters:
ADDR_WIDTH, 28, app_addr width; layout {1'b0, bank[2:0], row[13:0], col[9:0]}
APP_DATA_WIDTH, 256, data beat width
APP_MASK_WIDTH, 32, byte-mask width (APP_DATA_WIDTH/8)
IDX_W, 7, memory index bits (2^IDX_W entries of APP_DATA_WIDTH)
CALIB_CYCLES, 64, clk cycles from reset release to init_calib_complete
RD_LATENCY, 4, cycles from read accept to app_rd_data_valid (>=1)
STALL_PERIOD, 16, app_rdy forced low 1 cycle per period; 0 = never
REF_CYCLES, 8, app_rdy low duration per ref_req

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
app_en  in  1  command valid
app_cmd  in  3  000 write, 001 read, others illegal
app_addr  in  ADDR_WIDTH  command address
app_wdf_data  in  APP_DATA_WIDTH  write data
app_wdf_wren  in  1  write data valid
app_wdf_end  in  1  last beat (single-beat; must equal app_wdf_wren)
app_wdf_mask  in  APP_MASK_WIDTH  1 = byte NOT written
app_burst  in  1  ignored
sr_req  in  1  self-refresh request; treated like ref_req
ref_req  in  1  refresh request (pulse)
app_rdy  out  1  command accept
wr_data_rdy  out  1  write data accept
app_rd_data  out  APP_DATA_WIDTH  read data
app_rd_data_valid  out  1  read data valid
init_calib_complete  out  1  calibration done (sticky)
proto_err  out  1  sticky protocol violation flag
wr_count  out  32  accepted writes
rd_count  out  32  accepted reads

Behaviour:
- Reset (async, rst=1): all outputs 0; state CALIB; all counters 0; read pipeline cleared; memory contents undefined (sim: X).
- States: CALIB -> READY after CALIB_CYCLES clk edges; init_calib_complete=1 from the READY entry, sticky until rst. READY -> REFRESH on ref_req|sr_req; REFRESH -> READY after REF_CYCLES cycles. ref_req arriving during REFRESH restarts the count.
- app_rdy = (state==READY) & ~stall; stall = 1 when free-running period counter == STALL_PERIOD-1 (counter wraps to 0). wr_data_rdy = (state==READY). Both are 0 in CALIB and REFRESH.
- Accept = app_en & app_rdy. One command per cycle.
- Index: idx = col[9:3] ^ row[6:0] ^ {4'b0, bank}, truncated/zero-extended to IDX_W. Aliasing is intended.
- Write accept (app_cmd==000): requires app_wdf_wren & wr_data_rdy in the same cycle. Bytes with mask=0 update mem[idx] at that edge. wr_count +1.
- Read accept (app_cmd==001): mem[idx] is sampled at the accept edge; a write accepted on an earlier cycle is visible. Data and valid are pushed through a RD_LATENCY-stage pipeline. app_rd_data_valid=1 exactly RD_LATENCY cycles after the accept edge, for one cycle per read, in order. rd_count +1.
- Reads in flight drain normally through REFRESH and stalls.
- app_rd_data holds its last value when valid=0.
- Counters wrap at 2^32.
- proto_err set (sticky) on any of:
  - accept with illegal app_cmd (command dropped);
  - write accept without app_wdf_wren (memory untouched, write still counted);
  - app_wdf_wren without a write accept;
  - app_wdf_end != app_wdf_wren;
  - app_en asserted in CALIB.
- Mid-operation rst: the pipeline is flushed; no app_rd_data_valid appears for reads accepted before reset.

Optional Feature:
DDR_RESP_RAND_STALL_EN: when defined, stall comes from a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset), with stall = lfsr[3:0]==4'hF; STALL_PERIOD is ignored. wr_data_rdy is additionally low when lfsr[7:4]==4'h0. When undefined, the deterministic STALL_PERIOD pattern applies and wr_data_rdy follows state only.

Test Plan:
- Reset release, idle -> init_calib_complete rises on cycle 64; app_rdy 0 before; app_en=1 on cycle 10 sets proto_err.
- Write bank 0..7 with data {4{64'h1122334455667788}} etc.; read back bank 0..7 -> 8 valid beats, each 4 cycles after its accept, data matching in order; wr_count=8, rd_count=8; proto_err=0.
- STALL_PERIOD=16, continuous app_en reads -> app_rdy low exactly 1 of every 16 cycles; rd_count after 160 cycles = 150.
- Write all-ones to addr 0, then write 0 with mask 32'hFFFF_FFFE; read addr 0 -> byte 0 = 8'h00, bytes 1..31 = 8'hFF.
- ref_req pulse with 2 reads in flight -> app_rdy low 8 cycles; both valids still appear at +4 cycles; init_calib_complete stays 1.
- app_cmd=3'b010 accepted -> proto_err=1, no valid, counts unchanged; assert rst with 3 reads in flight -> no valid after release.
